// File: rtl/noc_endpoint_vc_buffer_pkg.sv
// Shared helpers for the per-virtual-channel endpoint flit buffer.
// Widths stay parameters, so the package only carries sizing helpers.
package noc_endpoint_vc_buffer_pkg;

    // Counter width that can represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/noc_endpoint_vc_fifo.sv
// Single-channel elastic flit FIFO with packet counting and a head FSM
// that gates out_valid in store-and-forward mode.
module noc_endpoint_vc_fifo
    import noc_endpoint_vc_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int FULLPACKET = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    typedef enum logic {
        HEAD_IDLE,
        HEAD_FWD
    } head_state_t;

    logic [FLIT_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       pkt_cnt;
    head_state_t         state;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic push_last;
    logic pop_last;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_flit  = mem[rd_ptr][FLIT_WIDTH-1:0];
    assign out_last  = mem[rd_ptr][FLIT_WIDTH];
    assign push_last = push && in_last;
    assign pop_last  = pop && out_last;

    // Store-and-forward holds the head back until a whole packet is in, unless
    // the FIFO is full (packet longer than DEPTH) or a packet is already flowing.
    always_comb begin
        out_valid = !empty;
        if (FULLPACKET != 0 && state == HEAD_IDLE) begin
            out_valid = !empty && (pkt_cnt != '0 || full);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_flit};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            pkt_cnt <= '0;
            state   <= HEAD_IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (push_last && !pop_last) begin
                pkt_cnt <= pkt_cnt + CW'(1);
            end else if (pop_last && !push_last) begin
                pkt_cnt <= pkt_cnt - CW'(1);
            end
            case (state)
                HEAD_IDLE: if (out_valid && !pop_last) state <= HEAD_FWD;
                HEAD_FWD:  if (pop_last) state <= HEAD_IDLE;
                default:   state <= HEAD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/noc_endpoint_vc_buffer.sv
// Per-virtual-channel elastic flit buffer between a router port and a tile
// interface; each channel is an independent FIFO with no cross-channel coupling.
module noc_endpoint_vc_buffer
    import noc_endpoint_vc_buffer_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 4,
    parameter int FULLPACKET = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  in_flit,
    input  logic [CHANNELS-1:0]                  in_last,
    input  logic [CHANNELS-1:0]                  in_valid,
    output logic [CHANNELS-1:0]                  in_ready,
    output logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
    output logic [CHANNELS-1:0]                  out_last,
    output logic [CHANNELS-1:0]                  out_valid,
    input  logic [CHANNELS-1:0]                  out_ready
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_channel
        noc_endpoint_vc_fifo #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEPTH      (DEPTH),
            .FULLPACKET (FULLPACKET)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .in_flit   (in_flit[c]),
            .in_last   (in_last[c]),
            .in_valid  (in_valid[c]),
            .in_ready  (in_ready[c]),
            .out_flit  (out_flit[c]),
            .out_last  (out_last[c]),
            .out_valid (out_valid[c]),
            .out_ready (out_ready[c])
        );
    end

endmodule

// File: tb/tb_noc_endpoint_vc_buffer.sv
// Directed bench for noc_endpoint_vc_buffer: one cut-through and one
// store-and-forward instance, driven at negedge and sampled 1ns later.
module tb_noc_endpoint_vc_buffer;

    localparam int FW = 32;
    localparam int CH = 2;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [CH-1:0][FW-1:0] ct_in_flit, ct_out_flit, sf_in_flit, sf_out_flit;
    logic [CH-1:0] ct_in_last, ct_in_valid, ct_in_ready, ct_out_last, ct_out_valid, ct_out_ready;
    logic [CH-1:0] sf_in_last, sf_in_valid, sf_in_ready, sf_out_last, sf_out_valid, sf_out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          vld;
        logic [FW-1:0] flit;
        logic          last;
        logic          ordy;
        logic          exp_irdy;
        logic          exp_ovld;
        logic [FW-1:0] exp_flit;
        logic          exp_last;
    } vec_t;

    vec_t ct_vec [9];
    vec_t sf_vec [9];

    noc_endpoint_vc_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DP), .FULLPACKET(0)) dut_ct (
        .clk(clk), .rst(rst),
        .in_flit(ct_in_flit), .in_last(ct_in_last), .in_valid(ct_in_valid), .in_ready(ct_in_ready),
        .out_flit(ct_out_flit), .out_last(ct_out_last), .out_valid(ct_out_valid), .out_ready(ct_out_ready)
    );

    noc_endpoint_vc_buffer #(.FLIT_WIDTH(FW), .CHANNELS(CH), .DEPTH(DP), .FULLPACKET(1)) dut_sf (
        .clk(clk), .rst(rst),
        .in_flit(sf_in_flit), .in_last(sf_in_last), .in_valid(sf_in_valid), .in_ready(sf_in_ready),
        .out_flit(sf_out_flit), .out_last(sf_out_last), .out_valid(sf_out_valid), .out_ready(sf_out_ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // One table cycle on channel 0 of the selected instance.
    task automatic applyStimulus(input vec_t v, input bit use_sf, input int idx);
        logic          irdy, ovld, olast;
        logic [FW-1:0] oflit;
        @(negedge clk);
        if (use_sf) begin
            sf_in_valid[0] = v.vld; sf_in_flit[0] = v.flit; sf_in_last[0] = v.last; sf_out_ready[0] = v.ordy;
        end else begin
            ct_in_valid[0] = v.vld; ct_in_flit[0] = v.flit; ct_in_last[0] = v.last; ct_out_ready[0] = v.ordy;
        end
        #1;
        irdy  = use_sf ? sf_in_ready[0]  : ct_in_ready[0];
        ovld  = use_sf ? sf_out_valid[0] : ct_out_valid[0];
        oflit = use_sf ? sf_out_flit[0]  : ct_out_flit[0];
        olast = use_sf ? sf_out_last[0]  : ct_out_last[0];
        checkOutput($sformatf("%s_vec%0d in_ready", use_sf ? "sf" : "ct", idx), 32'(irdy), 32'(v.exp_irdy));
        checkOutput($sformatf("%s_vec%0d out_valid", use_sf ? "sf" : "ct", idx), 32'(ovld), 32'(v.exp_ovld));
        if (v.exp_ovld) begin
            checkOutput($sformatf("%s_vec%0d out_flit", use_sf ? "sf" : "ct", idx), oflit, v.exp_flit);
            checkOutput($sformatf("%s_vec%0d out_last", use_sf ? "sf" : "ct", idx), 32'(olast), 32'(v.exp_last));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int push_idx;
        int exp_idx;
        int cyc;

        ct_vec[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        ct_vec[1] = '{1'b1, 32'hA1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b0};
        ct_vec[2] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1};
        ct_vec[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        ct_vec[4] = '{1'b1, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0};
        ct_vec[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'hC0, 1'b0};
        ct_vec[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 32'hC0, 1'b0};
        ct_vec[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hC0, 1'b0};
        ct_vec[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};

        sf_vec[0] = '{1'b1, 32'hB0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        sf_vec[1] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        sf_vec[2] = '{1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        sf_vec[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        sf_vec[4] = '{1'b1, 32'hB2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};
        sf_vec[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hB0, 1'b0};
        sf_vec[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hB1, 1'b0};
        sf_vec[7] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b1, 32'hB2, 1'b1};
        sf_vec[8] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0};

        ct_in_flit = '0; ct_in_last = '0; ct_in_valid = 2'b11; ct_out_ready = '0;
        sf_in_flit = '0; sf_in_last = '0; sf_in_valid = 2'b11; sf_out_ready = '0;

        // Reset held for three cycles with upstream valid asserted.
        repeat (3) begin
            @(negedge clk); #1;
            checkOutput("rst ct in_ready", 32'(ct_in_ready), 32'h0);
            checkOutput("rst ct out_valid", 32'(ct_out_valid), 32'h0);
            checkOutput("rst sf in_ready", 32'(sf_in_ready), 32'h0);
            checkOutput("rst sf out_valid", 32'(sf_out_valid), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0; ct_in_valid = '0; sf_in_valid = '0;
        #1;
        checkOutput("post-rst ct in_ready", 32'(ct_in_ready), 32'h3);
        checkOutput("post-rst sf in_ready", 32'(sf_in_ready), 32'h3);
        repeat (2) begin
            @(negedge clk); #1;
            checkOutput("post-rst ct out_valid", 32'(ct_out_valid), 32'h0);
            checkOutput("post-rst sf out_valid", 32'(sf_out_valid), 32'h0);
        end

        for (int i = 0; i < 9; i++) applyStimulus(ct_vec[i], 1'b0, i);
        for (int i = 0; i < 9; i++) applyStimulus(sf_vec[i], 1'b1, i);

        // Fill ch0 of the cut-through instance, then free one slot for a single cycle.
        ct_out_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ct_in_valid[0] = 1'b1; ct_in_flit[0] = 32'(i); ct_in_last[0] = 1'b0;
            #1;
            checkOutput($sformatf("bp fill%0d in_ready", i), 32'(ct_in_ready[0]), 32'h1);
        end
        @(negedge clk);
        ct_in_flit[0] = 32'd4;
        #1;
        checkOutput("bp full in_ready", 32'(ct_in_ready[0]), 32'h0);
        checkOutput("bp full out_valid", 32'(ct_out_valid[0]), 32'h1);
        checkOutput("bp full out_flit", ct_out_flit[0], 32'd0);
        @(negedge clk);
        ct_out_ready[0] = 1'b1;
        #1;
        checkOutput("bp pop-cycle in_ready", 32'(ct_in_ready[0]), 32'h0);
        checkOutput("bp pop-cycle out_flit", ct_out_flit[0], 32'd0);
        @(negedge clk);
        ct_out_ready[0] = 1'b0;
        #1;
        checkOutput("bp freed in_ready", 32'(ct_in_ready[0]), 32'h1);
        checkOutput("bp freed out_flit", ct_out_flit[0], 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ct_in_valid[0] = 1'b0; ct_out_ready[0] = 1'b1;
            #1;
            checkOutput($sformatf("bp drain%0d out_valid", k), 32'(ct_out_valid[0]), 32'h1);
            checkOutput($sformatf("bp drain%0d out_flit", k), ct_out_flit[0], 32'(k));
        end
        @(negedge clk); #1;
        checkOutput("bp empty out_valid", 32'(ct_out_valid[0]), 32'h0);

        // Deadlock escape: 6-flit packet into a 4-deep store-and-forward FIFO.
        sf_out_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sf_in_valid[0] = 1'b1; sf_in_flit[0] = 32'hD0 + 32'(i); sf_in_last[0] = 1'b0;
            #1;
            checkOutput($sformatf("esc fill%0d out_valid", i), 32'(sf_out_valid[0]), 32'h0);
        end
        @(negedge clk);
        sf_in_flit[0] = 32'hD4;
        #1;
        checkOutput("esc full in_ready", 32'(sf_in_ready[0]), 32'h0);
        checkOutput("esc full out_valid", 32'(sf_out_valid[0]), 32'h1);
        checkOutput("esc full out_flit", sf_out_flit[0], 32'hD0);
        push_idx = 4; exp_idx = 0; cyc = 0;
        while (exp_idx < 6 && cyc < 30) begin
            @(negedge clk);
            sf_in_valid[0]  = (push_idx < 6);
            sf_in_flit[0]   = 32'hD0 + 32'(push_idx);
            sf_in_last[0]   = (push_idx == 5);
            sf_out_ready[0] = 1'b1;
            #1;
            checkOutput($sformatf("esc cyc%0d out_valid", cyc), 32'(sf_out_valid[0]), 32'h1);
            if (sf_out_valid[0]) begin
                checkOutput($sformatf("esc flit%0d", exp_idx), sf_out_flit[0], 32'hD0 + 32'(exp_idx));
                checkOutput($sformatf("esc last%0d", exp_idx), 32'(sf_out_last[0]), 32'(exp_idx == 5));
                exp_idx++;
            end
            if (sf_in_valid[0] && sf_in_ready[0]) push_idx++;
            cyc++;
        end
        checkOutput("esc drained count", 32'(exp_idx), 32'd6);
        @(negedge clk);
        sf_in_valid[0] = 1'b1; sf_in_flit[0] = 32'hEE; sf_in_last[0] = 1'b0;
        #1;
        checkOutput("esc after out_valid", 32'(sf_out_valid[0]), 32'h0);
        @(negedge clk);
        sf_in_valid[0] = 1'b0;
        #1;
        checkOutput("sf idle partial out_valid", 32'(sf_out_valid[0]), 32'h0);

        // Channel independence: ch1 stalled full while ch0 streams 10 flits.
        ct_out_ready[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ct_in_valid[1] = 1'b1; ct_in_flit[1] = 32'hE0 + 32'(i); ct_in_last[1] = 1'b0;
            #1;
            checkOutput($sformatf("ch1 fill%0d in_ready", i), 32'(ct_in_ready[1]), 32'h1);
        end
        push_idx = 0; exp_idx = 0; cyc = 0;
        while (exp_idx < 10 && cyc < 40) begin
            @(negedge clk);
            ct_in_flit[1]   = 32'hE4;
            ct_in_valid[0]  = (push_idx < 10);
            ct_in_flit[0]   = 32'h100 + 32'(push_idx);
            ct_in_last[0]   = (push_idx == 9);
            ct_out_ready[0] = 1'b1;
            #1;
            checkOutput("indep ch1 in_ready", 32'(ct_in_ready[1]), 32'h0);
            checkOutput("indep ch1 out_flit", ct_out_flit[1], 32'hE0);
            checkOutput("indep ch0 in_ready", 32'(ct_in_ready[0]), 32'h1);
            if (ct_out_valid[0]) begin
                checkOutput($sformatf("indep flit%0d", exp_idx), ct_out_flit[0], 32'h100 + 32'(exp_idx));
                checkOutput($sformatf("indep last%0d", exp_idx), 32'(ct_out_last[0]), 32'(exp_idx == 9));
                exp_idx++;
            end
            if (ct_in_valid[0] && ct_in_ready[0]) push_idx++;
            cyc++;
        end
        checkOutput("indep streamed count", 32'(exp_idx), 32'd10);

        // Mid-packet reset discards everything buffered.
        ct_out_ready[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            ct_in_valid[0] = 1'b1; ct_in_flit[0] = 32'hF0 + 32'(i); ct_in_last[0] = 1'b0;
        end
        @(negedge clk);
        ct_in_valid[0] = 1'b0;
        #1;
        checkOutput("pre-rst ch0 out_valid", 32'(ct_out_valid[0]), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid-rst ct out_valid", 32'(ct_out_valid), 32'h0);
        checkOutput("mid-rst ct in_ready", 32'(ct_in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0; ct_in_valid = '0; sf_in_valid = '0; ct_out_ready = 2'b11;
        #1;
        checkOutput("after-rst ct out_valid", 32'(ct_out_valid), 32'h0);
        checkOutput("after-rst ct in_ready", 32'(ct_in_ready), 32'h3);
        checkOutput("after-rst sf out_valid", 32'(sf_out_valid), 32'h0);
        @(negedge clk); #1;
        checkOutput("after-rst+1 ct out_valid", 32'(ct_out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
